// File: rtl/gray_seq.sv
// gray_seq: one-hot mode select driven 8-bit pattern generator with prescaled stepping.
// Modes: binary, Gray, Johnson, LFSR, walking-one, ping-pong; per-mode seed reload on mode change.
module gray_seq #(
    parameter int unsigned pDIV_W = 16,
    parameter bit          pTEST  = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_sel,
    input  logic       i_en,
    output logic [7:0] o_out,
    output logic [2:0] o_mode,
    output logic       o_tick,
    output logic       o_wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_PONG  = 3'd1;
    localparam logic [2:0] M_WALK  = 3'd2;
    localparam logic [2:0] M_LFSR  = 3'd3;
    localparam logic [2:0] M_JOHN  = 3'd4;
    localparam logic [2:0] M_GRAY  = 3'd5;
    localparam logic [2:0] M_BIN   = 3'd6;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    state_t              state;
    logic [pDIV_W-1:0]   presc;
    logic [7:0]          seq_s;
    logic                dir;

    logic [2:0]          sel_mode;
    logic [7:0]          seed;
    logic                tick_c;
    logic [7:0]          nxt_s;
    logic [7:0]          nxt_out;
    logic                nxt_dir;

    // Priority decode of the one-hot select: highest set bit wins.
    always_comb begin
        sel_mode = M_IDLE;
        if (i_sel[5])      sel_mode = M_BIN;
        else if (i_sel[4]) sel_mode = M_GRAY;
        else if (i_sel[3]) sel_mode = M_JOHN;
        else if (i_sel[2]) sel_mode = M_LFSR;
        else if (i_sel[1]) sel_mode = M_WALK;
        else if (i_sel[0]) sel_mode = M_PONG;
    end

    // Seed for the stored mode; shift-based patterns need a set bit to start from.
    always_comb begin
        seed = 8'h00;
        if (o_mode == M_LFSR || o_mode == M_WALK || o_mode == M_PONG) seed = 8'h01;
    end

    // Step strobe: every enabled cycle in test mode, else once per prescaler roll-over.
    always_comb begin
        tick_c = i_en & (pTEST ? 1'b1 : (presc == '1));
    end

    // Next sequence state and visible value for one step of the stored mode.
    always_comb begin
        nxt_s   = seq_s;
        nxt_out = seq_s;
        nxt_dir = dir;
        case (o_mode)
            M_BIN: begin
                nxt_s   = seq_s + 8'd1;
                nxt_out = nxt_s;
            end
            M_GRAY: begin
                nxt_s   = seq_s + 8'd1;
                nxt_out = nxt_s ^ (nxt_s >> 1);
            end
            M_JOHN: begin
                nxt_s   = {seq_s[6:0], ~seq_s[7]};
                nxt_out = nxt_s;
            end
            M_LFSR: begin
                nxt_s   = {seq_s[6:0], seq_s[7] ^ seq_s[5] ^ seq_s[4] ^ seq_s[3]};
                nxt_out = nxt_s;
            end
            M_WALK: begin
                nxt_s   = {seq_s[6:0], seq_s[7]};
                nxt_out = nxt_s;
            end
            M_PONG: begin
                if (dir == DIR_LEFT) begin
                    nxt_s = {seq_s[6:0], 1'b0};
                    if (nxt_s == 8'h80) nxt_dir = DIR_RIGHT;
                end else begin
                    nxt_s = {1'b0, seq_s[7:1]};
                    if (nxt_s == 8'h01) nxt_dir = DIR_LEFT;
                end
                nxt_out = nxt_s;
            end
            default: begin
                nxt_s   = 8'h00;
                nxt_out = 8'h00;
            end
        endcase
    end

    // Mode tracking FSM, prescaler and registered outputs; mode change beats stepping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            presc  <= '0;
            seq_s  <= 8'h00;
            dir    <= DIR_LEFT;
            o_out  <= 8'h00;
            o_mode <= M_IDLE;
            o_tick <= 1'b0;
            o_wrap <= 1'b0;
        end else begin
            o_tick <= 1'b0;
            o_wrap <= 1'b0;
            if (sel_mode != o_mode) begin
                o_mode <= sel_mode;
                presc  <= '0;
                state  <= ST_LOAD;
            end else begin
                case (state)
                    ST_IDLE: begin
                        o_out <= 8'h00;
                    end
                    ST_LOAD: begin
                        if (o_mode == M_IDLE) begin
                            o_out <= 8'h00;
                            state <= ST_IDLE;
                        end else begin
                            o_out <= seed;
                            seq_s <= seed;
                            dir   <= DIR_LEFT;
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (i_en) begin
                            presc <= presc + pDIV_W'(1);
                            if (tick_c) begin
                                seq_s  <= nxt_s;
                                o_out  <= nxt_out;
                                dir    <= nxt_dir;
                                o_tick <= 1'b1;
                                o_wrap <= (nxt_out == seed);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_seq.sv
// tb_gray_seq: directed + randomized checks of gray_seq against a closed-form sequence model.
module tb_gray_seq;

    logic       clk;
    logic       rst_n;
    logic [5:0] sel1, sel0;
    logic       en1, en0;
    logic [7:0] out1, out0;
    logic [2:0] mode1, mode0;
    logic       tick1, tick0, wrap1, wrap0;

    int n_assert = 0;
    int n_fail   = 0;
    bit seen [256];

    gray_seq #(.pDIV_W(16), .pTEST(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel1), .i_en(en1),
        .o_out(out1), .o_mode(mode1), .o_tick(tick1), .o_wrap(wrap1)
    );

    gray_seq #(.pDIV_W(2), .pTEST(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel0), .i_en(en0),
        .o_out(out0), .o_mode(mode0), .o_tick(tick0), .o_wrap(wrap0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    function automatic int period(input int m);
        case (m)
            6, 5:    return 256;
            4:       return 16;
            3:       return 255;
            2:       return 8;
            default: return 14;
        endcase
    endfunction

    function automatic logic [7:0] seed_of(input int m);
        return (m >= 1 && m <= 3) ? 8'h01 : 8'h00;
    endfunction

    // Value after k steps from the seed, straight from the pattern definitions.
    function automatic logic [7:0] exp_val(input int m, input int k);
        logic [7:0] b;
        int p;
        case (m)
            6: return 8'(k % 256);
            5: begin b = 8'(k % 256); return b ^ (b >> 1); end
            4: begin
                p = k % 16;
                if (p < 8) return 8'((1 << p) - 1);
                return 8'((32'hFF << (p - 8)) & 32'hFF);
            end
            3: begin
                b = 8'h01;
                repeat (k % 255) b = {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
                return b;
            end
            2: return 8'(1 << (k % 8));
            default: begin
                p = k % 14;
                return (p <= 7) ? 8'(1 << p) : 8'(1 << (14 - p));
            end
        endcase
    endfunction

    // Select mode m (random lower bits added to exercise priority), then take n ticks with random enable.
    task automatic run_mode(input int m, input int n);
        int k, cyc, distinct;
        logic e;
        sel1 = 6'(6'b1 << (m - 1)) | 6'($urandom_range(0, (1 << (m - 1)) - 1));
        step1();
        chk("load_mode", 32'(mode1), 32'(m));
        chk("load_tick", 32'(tick1), 0);
        chk("load_wrap", 32'(wrap1), 0);
        step1();
        chk("seed_out", 32'(out1), 32'(seed_of(m)));
        chk("seed_tick", 32'(tick1), 0);
        k = 0; cyc = 0; distinct = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        while (k < n && cyc < 8 * n + 20) begin
            e = ($urandom_range(0, 3) != 0);
            en1 = e;
            step1();
            cyc++;
            if (e) k++;
            chk("seq_out", 32'(out1), 32'(exp_val(m, k)));
            chk("seq_tick", 32'(tick1), 32'(e));
            chk("seq_wrap", 32'(wrap1), 32'(e && (k % period(m) == 0)));
            if (m == 3 && e) begin
                chk("lfsr_nonzero", 32'(out1 != 8'h00), 1);
                if (k <= 255 && !seen[out1]) begin
                    seen[out1] = 1'b1;
                    distinct++;
                end
            end
        end
        chk("run_budget", 32'(k), 32'(n));
        if (m == 3) chk("lfsr_distinct", 32'(distinct), 255);
        en1 = 1'b1;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; sel1 = '0; sel0 = '0; en1 = 1'b0; en0 = 1'b0;
        #12;
        chk("rst_out", 32'(out1), 0);
        chk("rst_mode", 32'(mode1), 0);
        chk("rst_tick", 32'(tick1), 0);
        chk("rst_wrap", 32'(wrap1), 0);
        chk("rst_out0", 32'(out0), 0);
        rst_n = 1'b1;
        en1 = 1'b1;

        run_mode(5, 260);   // Gray, through the 256-tick wrap
        run_mode(3, 260);   // LFSR, through the 255-tick wrap
        run_mode(1, 30);    // ping-pong, two periods
        run_mode(4, 20);    // Johnson, returns to 00 after 16
        run_mode(6, 10);    // binary

        // Walking-one to 0x10, then switch to binary: no step during the reload.
        run_mode(2, 4);
        chk("walk_at_10", 32'(out1), 32'h10);
        en1 = 1'b1;
        sel1 = 6'b100000;
        step1();
        chk("sw_mode", 32'(mode1), 6);
        chk("sw_tick1", 32'(tick1), 0);
        chk("sw_wrap1", 32'(wrap1), 0);
        step1();
        chk("sw_out", 32'(out1), 0);
        chk("sw_tick2", 32'(tick1), 0);
        chk("sw_wrap2", 32'(wrap1), 0);
        step1();
        chk("bin_step", 32'(out1), 1);

        // Mode change while still loading: newer mode's seed wins.
        sel1 = 6'b010000;
        step1();
        chk("rl_mode1", 32'(mode1), 5);
        sel1 = 6'b000010;
        step1();
        chk("rl_mode2", 32'(mode1), 2);
        chk("rl_tick", 32'(tick1), 0);
        step1();
        chk("rl_out", 32'(out1), 1);
        chk("rl_tick2", 32'(tick1), 0);

        // Prescaled instance: binary mode, one tick per 4 enabled cycles.
        sel0 = 6'b100000; en0 = 1'b1;
        step1();
        chk("p_mode", 32'(mode0), 6);
        step1();
        chk("p_seed", 32'(out0), 0);
        for (int t = 1; t <= 2; t++) begin
            cyc = 0;
            do begin step1(); cyc++; end while (!tick0 && cyc < 20);
            chk("p_interval", 32'(cyc), 4);
            chk("p_out", 32'(out0), 32'(t));
        end
        cyc = 0;
        do begin
            en0 = (cyc >= 2 && cyc < 5) ? 1'b0 : 1'b1;
            step1();
            cyc++;
        end while (!tick0 && cyc < 20);
        en0 = 1'b1;
        chk("p_en_gap", 32'(cyc), 7);
        chk("p_out3", 32'(out0), 3);

        // Asynchronous reset between edges mid-run, walking-one still selected.
        step1(); step1(); step1();
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_out", 32'(out1), 0);
        chk("ar_mode", 32'(mode1), 0);
        chk("ar_tick", 32'(tick1), 0);
        chk("ar_out0", 32'(out0), 0);
        chk("ar_mode0", 32'(mode0), 0);
        #1;
        rst_n = 1'b1;
        step1();
        chk("ar_reload_mode", 32'(mode1), 2);
        step1();
        chk("ar_reload_out", 32'(out1), 1);

        // Reset again with idle select: stays idle, no ticks.
        #2;
        rst_n = 1'b0;
        sel1 = '0; sel0 = '0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step1();
            chk("idle_out", 32'(out1), 0);
            chk("idle_mode", 32'(mode1), 0);
            chk("idle_tick", 32'(tick1 | tick0), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
